// File: rtl/fpu_misc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpu_misc_pipe : two-stage FP sign-inject / min-max / compare / class |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fpu_misc_pipe #(
  parameter  int EXP_W   = 5,
  parameter  int FRAC_W  = 10,
  parameter  int WORD_W  = 32,
  parameter  int TAG_W   = 5,
  parameter  int NAN_BOX = 1,
  localparam int FP_W    = 1 + EXP_W + FRAC_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        funct5,
  input  logic [2:0]        rm,
  input  logic [FP_W-1:0]   rs1,
  input  logic [FP_W-1:0]   rs2,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] result,
  output logic [TAG_W-1:0]  tag_out,
  output logic              flag_nv,
  output logic              flag_illegal
);

  localparam logic [4:0] F5_SGNJ   = 5'b00100;
  localparam logic [4:0] F5_MINMAX = 5'b00101;
  localparam logic [4:0] F5_COMP   = 5'b10100;
  localparam logic [4:0] F5_CLASS  = 5'b11100;

  localparam int CL_ZERO = 0;
  localparam int CL_SUB  = 1;
  localparam int CL_NORM = 2;
  localparam int CL_INF  = 3;
  localparam int CL_SNAN = 4;
  localparam int CL_QNAN = 5;

  localparam logic [FP_W-1:0]   CANON_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [WORD_W-1:0] BOX_MASK   = (NAN_BOX != 0) ? ({WORD_W{1'b1}} << FP_W) : '0;

  function automatic logic [5:0] classify(input logic [FP_W-1:0] x);
    logic exp_ones, exp_zero, frac_zero;
    exp_ones  = &x[FP_W-2:FRAC_W];
    exp_zero  = ~|x[FP_W-2:FRAC_W];
    frac_zero = ~|x[FRAC_W-1:0];
    classify          = '0;
    classify[CL_ZERO] = exp_zero & frac_zero;
    classify[CL_SUB]  = exp_zero & ~frac_zero;
    classify[CL_NORM] = ~exp_ones & ~exp_zero;
    classify[CL_INF]  = exp_ones & frac_zero;
    classify[CL_SNAN] = exp_ones & ~x[FRAC_W-1] & ~frac_zero;
    classify[CL_QNAN] = exp_ones & x[FRAC_W-1];
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [FP_W-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [4:0]        s1_f5_q, s1_f5_d;
  logic [2:0]        s1_rm_q, s1_rm_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [5:0]        s1_ca_q, s1_ca_d, s1_cb_q, s1_cb_d;

  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              nv_q, nv_d, ill_q, ill_d;

  logic s2_adv, s1_adv;
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_f5_d    = s1_f5_q;
    s1_rm_d    = s1_rm_q;
    s1_tag_d   = s1_tag_q;
    s1_ca_d    = s1_ca_q;
    s1_cb_d    = s1_cb_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d   = rs1;
        s1_b_d   = rs2;
        s1_f5_d  = funct5;
        s1_rm_d  = rm;
        s1_tag_d = tag_in;
        s1_ca_d  = classify(rs1);
        s1_cb_d  = classify(rs2);
      end
    end
  end

  logic              a_sign, b_sign, a_nan, b_nan, any_snan, both_zero;
  logic [FP_W-2:0]   a_mag, b_mag;
  logic              lt_mz, lt, eq, cmp, sgn;
  logic [FP_W-1:0]   fp_res;
  logic [9:0]        int_res;
  logic              is_fp, c_nv, c_ill;
  logic [WORD_W-1:0] calc_res;
  logic              unused_cls_b;

  assign unused_cls_b = ^{s1_cb_q[CL_SUB], s1_cb_q[CL_NORM], s1_cb_q[CL_INF]};

  always_comb begin
    a_sign    = s1_a_q[FP_W-1];
    b_sign    = s1_b_q[FP_W-1];
    a_mag     = s1_a_q[FP_W-2:0];
    b_mag     = s1_b_q[FP_W-2:0];
    a_nan     = s1_ca_q[CL_SNAN] | s1_ca_q[CL_QNAN];
    b_nan     = s1_cb_q[CL_SNAN] | s1_cb_q[CL_QNAN];
    any_snan  = s1_ca_q[CL_SNAN] | s1_cb_q[CL_SNAN];
    both_zero = s1_ca_q[CL_ZERO] & s1_cb_q[CL_ZERO];
    // lt_mz orders -0 below +0 (min/max); lt/eq treat the zeros as equal
    if (a_sign != b_sign) lt_mz = a_sign;
    else if (a_sign)      lt_mz = b_mag < a_mag;
    else                  lt_mz = a_mag < b_mag;
    lt       = lt_mz && !both_zero;
    eq       = (s1_a_q == s1_b_q) || both_zero;
    cmp      = 1'b0;
    sgn      = 1'b0;
    fp_res   = '0;
    int_res  = '0;
    is_fp    = 1'b0;
    c_nv     = 1'b0;
    c_ill    = 1'b0;
    case (s1_f5_q)
      F5_SGNJ: begin
        is_fp = 1'b1;
        case (s1_rm_q)
          3'b000:  sgn = b_sign;
          3'b001:  sgn = ~b_sign;
          3'b010:  sgn = a_sign ^ b_sign;
          default: c_ill = 1'b1;
        endcase
        fp_res = {sgn, a_mag};
      end
      F5_MINMAX: begin
        is_fp = 1'b1;
        c_nv  = any_snan;
        if (a_nan && b_nan)     fp_res = CANON_QNAN;
        else if (a_nan)         fp_res = s1_b_q;
        else if (b_nan)         fp_res = s1_a_q;
        else if (s1_rm_q[0])    fp_res = lt_mz ? s1_b_q : s1_a_q;
        else                    fp_res = lt_mz ? s1_a_q : s1_b_q;
        if (s1_rm_q[2:1] != 2'b00) c_ill = 1'b1;
      end
      F5_COMP: begin
        case (s1_rm_q)
          3'b010:  begin cmp = eq;       c_nv = any_snan;      end
          3'b001:  begin cmp = lt;       c_nv = a_nan | b_nan; end
          3'b000:  begin cmp = lt || eq; c_nv = a_nan | b_nan; end
          default: c_ill = 1'b1;
        endcase
        int_res[0] = cmp && !a_nan && !b_nan;
      end
      F5_CLASS: begin
        int_res = {s1_ca_q[CL_QNAN], s1_ca_q[CL_SNAN],
                   ~a_sign & s1_ca_q[CL_INF],  ~a_sign & s1_ca_q[CL_NORM],
                   ~a_sign & s1_ca_q[CL_SUB],  ~a_sign & s1_ca_q[CL_ZERO],
                   a_sign & s1_ca_q[CL_ZERO],  a_sign & s1_ca_q[CL_SUB],
                   a_sign & s1_ca_q[CL_NORM],  a_sign & s1_ca_q[CL_INF]};
      end
      default: c_ill = 1'b1;
    endcase
    calc_res = '0;
    if (c_ill) begin
      c_nv = 1'b0;
    end else if (is_fp) begin
      calc_res              = BOX_MASK;
      calc_res[FP_W-1:0]    = fp_res;
    end else begin
      calc_res[9:0]         = int_res;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    tag_d       = tag_q;
    nv_d        = nv_q;
    ill_d       = ill_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      result_d    = s1_valid_q ? calc_res : '0;
      tag_d       = s1_valid_q ? s1_tag_q : '0;
      nv_d        = s1_valid_q & c_nv;
      ill_d       = s1_valid_q & c_ill;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_f5_q     <= '0;
      s1_rm_q     <= '0;
      s1_tag_q    <= '0;
      s1_ca_q     <= '0;
      s1_cb_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      nv_q        <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_f5_q     <= s1_f5_d;
      s1_rm_q     <= s1_rm_d;
      s1_tag_q    <= s1_tag_d;
      s1_ca_q     <= s1_ca_d;
      s1_cb_q     <= s1_cb_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
      nv_q        <= nv_d;
      ill_q       <= ill_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign tag_out      = tag_q;
  assign flag_nv      = nv_q;
  assign flag_illegal = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_misc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fpu_misc_pipe : directed bench for fpu_misc_pipe (half precision) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fpu_misc_pipe;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  funct5;
  logic [2:0]  rm;
  logic [15:0] rs1, rs2;
  logic [4:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  tag_out;
  logic        flag_nv;
  logic        flag_illegal;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] SGNJ = 5'b00100, MINMAX = 5'b00101, COMP = 5'b10100, CLASS = 5'b11100;

  fpu_misc_pipe dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct5(funct5), .rm(rm), .rs1(rs1), .rs2(rs2), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tag_out(tag_out),
    .flag_nv(flag_nv), .flag_illegal(flag_illegal)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] f, input logic [2:0] r, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] t);
    in_valid = 1'b1;
    funct5   = f;
    rm       = r;
    rs1      = a;
    rs2      = b;
    tag_in   = t;
  endtask

  task automatic single(input string nm, input logic [4:0] f, input logic [2:0] r,
                        input logic [15:0] a, input logic [15:0] b, input logic [4:0] t,
                        input logic [31:0] er, input logic env, input logic eil);
    drive(f, r, a, b, t);
    step();
    in_valid = 1'b0;
    step();
    chk({nm, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, ".result"}, result, er);
    chk({nm, ".tag"}, {27'd0, tag_out}, {27'd0, t});
    chk({nm, ".nv"}, {31'd0, flag_nv}, {31'd0, env});
    chk({nm, ".illegal"}, {31'd0, flag_illegal}, {31'd0, eil});
    step();
  endtask

  initial begin
    nRST = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    funct5 = '0; rm = '0; rs1 = '0; rs2 = '0; tag_in = '0;
    step(); step();
    chk("rst.valid",   {31'd0, out_valid}, 32'd0);
    chk("rst.result",  result, 32'd0);
    chk("rst.tag",     {27'd0, tag_out}, 32'd0);
    chk("rst.nv",      {31'd0, flag_nv}, 32'd0);
    chk("rst.illegal", {31'd0, flag_illegal}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    nRST = 1'b1;
    step();

    // Latency: nothing visible one edge after acceptance, valid on the next
    drive(MINMAX, 3'b000, 16'h0000, 16'h8000, 5'd3);
    step();
    in_valid = 1'b0;
    chk("fmin0.early", {31'd0, out_valid}, 32'd0);
    step();
    chk("fmin0.valid",  {31'd0, out_valid}, 32'd1);
    chk("fmin0.result", result, 32'hFFFF8000);
    chk("fmin0.tag",    {27'd0, tag_out}, 32'd3);
    chk("fmin0.nv",     {31'd0, flag_nv}, 32'd0);
    step();
    chk("fmin0.drain",  {31'd0, out_valid}, 32'd0);
    chk("fmin0.flag0",  {31'd0, flag_nv | flag_illegal}, 32'd0);

    single("fmax_snan", MINMAX, 3'b001, 16'h7C01, 16'h3C00, 5'd1, 32'hFFFF3C00, 1'b1, 1'b0);
    single("fmax_qq",   MINMAX, 3'b001, 16'h7E00, 16'h7E00, 5'd2, 32'hFFFF7E00, 1'b0, 1'b0);
    single("fmin_neg",  MINMAX, 3'b000, 16'hBC00, 16'h3C00, 5'd4, 32'hFFFFBC00, 1'b0, 1'b0);
    single("flt_nan",   COMP,   3'b001, 16'h7E00, 16'h3C00, 5'd5, 32'h00000000, 1'b1, 1'b0);
    single("feq_nan",   COMP,   3'b010, 16'h7E00, 16'h3C00, 5'd6, 32'h00000000, 1'b0, 1'b0);
    single("feq_zero",  COMP,   3'b010, 16'h0000, 16'h8000, 5'd7, 32'h00000001, 1'b0, 1'b0);
    single("flt_neg",   COMP,   3'b001, 16'hC000, 16'hBC00, 5'd8, 32'h00000001, 1'b0, 1'b0);
    single("fle_eq",    COMP,   3'b000, 16'h3C00, 16'h3C00, 5'd9, 32'h00000001, 1'b0, 1'b0);
    single("fsgnjn",    SGNJ,   3'b001, 16'h3C00, 16'h0000, 5'd10, 32'hFFFFBC00, 1'b0, 1'b0);
    single("fsgnjx",    SGNJ,   3'b010, 16'hBC00, 16'hC000, 5'd11, 32'hFFFF3C00, 1'b0, 1'b0);
    single("cls_psub",  CLASS,  3'b000, 16'h0001, 16'h7C01, 5'd12, 32'h00000020, 1'b0, 1'b0);
    single("cls_ninf",  CLASS,  3'b001, 16'hFC00, 16'h0000, 5'd13, 32'h00000001, 1'b0, 1'b0);
    single("cls_snan",  CLASS,  3'b000, 16'h7C01, 16'h0000, 5'd14, 32'h00000100, 1'b0, 1'b0);
    single("cls_qnan",  CLASS,  3'b000, 16'h7E00, 16'h0000, 5'd15, 32'h00000200, 1'b0, 1'b0);
    single("cls_nzero", CLASS,  3'b000, 16'h8000, 16'h0000, 5'd16, 32'h00000008, 1'b0, 1'b0);
    single("ill_f5",    5'b01111, 3'b000, 16'h7C01, 16'h7C01, 5'd17, 32'h00000000, 1'b0, 1'b1);
    single("ill_sgnj",  SGNJ,   3'b011, 16'h3C00, 16'h8000, 5'd18, 32'h00000000, 1'b0, 1'b1);
    single("ill_comp",  COMP,   3'b011, 16'h7C01, 16'h3C00, 5'd19, 32'h00000000, 1'b0, 1'b1);

    // Stall: consumer blocked while four ops are issued back to back
    out_ready = 1'b0;
    drive(SGNJ, 3'b000, 16'h3C00, 16'h8000, 5'd1);
    #1 chk("stall.rdy0", {31'd0, in_ready}, 32'd1);
    step();
    drive(CLASS, 3'b000, 16'hFC00, 16'h0000, 5'd2);
    #1 chk("stall.rdy1", {31'd0, in_ready}, 32'd1);
    step();
    drive(COMP, 3'b010, 16'h3C00, 16'h3C00, 5'd4);
    #1 chk("stall.rdy2", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall.valid",  {31'd0, out_valid}, 32'd1);
      chk("stall.result", result, 32'hFFFFBC00);
      chk("stall.tag",    {27'd0, tag_out}, 32'd1);
      chk("stall.rdy",    {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("stall.rdy_rel", {31'd0, in_ready}, 32'd1);
    step();
    chk("ret1.result", result, 32'h00000001);
    chk("ret1.tag",    {27'd0, tag_out}, 32'd2);
    drive(MINMAX, 3'b001, 16'h3C00, 16'h4000, 5'd5);
    step();
    in_valid = 1'b0;
    chk("ret2.result", result, 32'h00000001);
    chk("ret2.tag",    {27'd0, tag_out}, 32'd4);
    step();
    chk("ret3.valid",  {31'd0, out_valid}, 32'd1);
    chk("ret3.result", result, 32'hFFFF4000);
    chk("ret3.tag",    {27'd0, tag_out}, 32'd5);
    step();
    chk("ret.drain",   {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with two ops in flight
    drive(SGNJ, 3'b000, 16'h3C00, 16'h0000, 5'd6);
    step();
    drive(SGNJ, 3'b001, 16'h3C00, 16'h0000, 5'd7);
    step();
    in_valid = 1'b0;
    chk("arst.pre", {31'd0, out_valid}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("arst.valid",  {31'd0, out_valid}, 32'd0);
    chk("arst.result", result, 32'd0);
    chk("arst.tag",    {27'd0, tag_out}, 32'd0);
    #2 nRST = 1'b1;
    #1 chk("arst.rdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("arst.stale0", {31'd0, out_valid}, 32'd0);
    step();
    chk("arst.stale1", {31'd0, out_valid}, 32'd0);
    chk("arst.stale1r", result, 32'd0);
    single("post_rst", MINMAX, 3'b000, 16'h3C00, 16'h4000, 5'd9, 32'hFFFF3C00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
